// File: rtl/reg_share_arbiter_if.sv
// Requester-side bundle of the shared-register arbiter: request/data in,
// grant/owner/busy/register contents out.
interface reg_share_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8
);
   logic [N_REQ-1:0]         req;
   logic [N_REQ*WIDTH-1:0]   wr_data;
   logic [N_REQ-1:0]         gnt;
   logic [$clog2(N_REQ)-1:0] owner;
   logic                     busy;
   logic [WIDTH-1:0]         q;

   // Requester logic drives requests and data, observes the grant.
   modport master (
      output req, wr_data,
      input  gnt, owner, busy, q
   );

   // The arbiter samples requests and data, owns every output.
   modport slave (
      input  req, wr_data,
      output gnt, owner, busy, q
   );
endinterface

// File: rtl/reg_share_arbiter.sv
// Round-robin write arbiter for one shared WIDTH-bit register. One requester
// owns the register at a time; each owner is capped at MAX_HOLD write beats
// before access is forced back through an IDLE arbitration cycle.
module reg_share_arbiter #(
   parameter int N_REQ    = 4,
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              rst,
   reg_share_arbiter_if.slave bus
);
   localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
   localparam logic [OW-1:0] LAST_INIT = OW'(N_REQ - 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t           state_reg;
   logic [OW-1:0]    last_reg;
   logic [HW-1:0]    hold_cnt_reg;
   logic [N_REQ-1:0] gnt_reg;
   logic [OW-1:0]    owner_reg;
   logic             busy_reg;
   logic [WIDTH-1:0] q_reg;

   logic [WIDTH-1:0] data_arr [N_REQ];
   logic [OW-1:0]    winner_idx;
   logic             owner_req;
   logic [WIDTH-1:0] owner_data;

   // Split the flat data bus into one word per requester.
   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_data
         assign data_arr[gi] = bus.wr_data[gi*WIDTH +: WIDTH];
      end
   endgenerate

   assign owner_req  = bus.req[owner_reg];
   assign owner_data = data_arr[owner_reg];

   // Round-robin pick: first set request scanning upward from last+1, wrapping.
   always_comb begin
      int  idx;
      logic found;
      idx        = 0;
      found      = 1'b0;
      winner_idx = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = int'(last_reg) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && bus.req[idx]) begin
            winner_idx = OW'(idx);
            found      = 1'b1;
         end
      end
   end

   // Arbitration FSM; every output is a register, no input-to-output paths.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= S_IDLE;
         last_reg     <= LAST_INIT;
         hold_cnt_reg <= '0;
         gnt_reg      <= '0;
         owner_reg    <= '0;
         busy_reg     <= 1'b0;
         q_reg        <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (|bus.req) begin
                  gnt_reg      <= {{(N_REQ-1){1'b0}}, 1'b1} << winner_idx;
                  owner_reg    <= winner_idx;
                  busy_reg     <= 1'b1;
                  hold_cnt_reg <= '0;
                  state_reg    <= S_GRANT;
               end
            end
            S_GRANT: begin
               // A write beat lands whenever the owner is still requesting;
               // the last allowed beat doubles as the release edge.
               if (owner_req) begin
                  q_reg <= owner_data;
               end
               if (owner_req && (hold_cnt_reg != HOLD_LAST)) begin
                  hold_cnt_reg <= hold_cnt_reg + 1'b1;
               end else begin
                  gnt_reg      <= '0;
                  busy_reg     <= 1'b0;
                  last_reg     <= owner_reg;
                  hold_cnt_reg <= '0;
                  state_reg    <= S_IDLE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign bus.gnt   = gnt_reg;
   assign bus.owner = owner_reg;
   assign bus.busy  = busy_reg;
   assign bus.q     = q_reg;
endmodule

// File: tb/tb_reg_share_arbiter.sv
// Bench for reg_share_arbiter: directed stimulus, a beat-counting model of
// the arbitration rules checked every cycle, plus literal checkpoints.
module tb_reg_share_arbiter;
   localparam int N   = 4;
   localparam int W   = 8;
   localparam int MH  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic model_on = 1'b0;

   reg_share_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

   reg_share_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Model state: who holds the grant (-1 = nobody), beats written so far,
   // previous grantee, reported owner and register contents.
   int         m_holder;
   int         m_beats;
   int         m_last;
   int         m_owner;
   logic [7:0] m_q;

   function automatic int rr_pick(input logic [3:0] r, input int last);
      for (int k = 1; k <= N; k++) begin
         if (r[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [7:0] word(input logic [31:0] d, input int i);
      return d[i*W +: W];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour, advanced on the same edges as the design.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_holder <= -1;
         m_beats  <= 0;
         m_last   <= N - 1;
         m_owner  <= 0;
         m_q      <= 8'h00;
      end else if (m_holder < 0) begin
         if (bus.req != 0) begin
            m_holder <= rr_pick(bus.req, m_last);
            m_owner  <= rr_pick(bus.req, m_last);
            m_beats  <= 0;
         end
      end else if (bus.req[m_holder]) begin
         m_q <= word(bus.wr_data, m_holder);
         if (m_beats + 1 == MH) begin
            m_last   <= m_holder;
            m_holder <= -1;
            m_beats  <= 0;
         end else begin
            m_beats <= m_beats + 1;
         end
      end else begin
         m_last   <= m_holder;
         m_holder <= -1;
         m_beats  <= 0;
      end
   end

   // Every-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      if (model_on) begin
         check("gnt",   32'(bus.gnt),   (m_holder < 0) ? 32'd0 : (32'd1 << m_holder));
         check("busy",  32'(bus.busy),  (m_holder < 0) ? 32'd0 : 32'd1);
         check("owner", 32'(bus.owner), 32'(m_owner));
         check("q",     32'(bus.q),     32'(m_q));
      end
   end

   // Advance n rising edges, then settle 3 time units past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #3;
   endtask

   task automatic set_data(input int i, input logic [7:0] v);
      bus.wr_data[i*W +: W] = v;
   endtask

   initial begin
      bus.req     = '0;
      bus.wr_data = '0;
      #1 rst = 1'b0;
      model_on = 1'b1;

      // Reset held with random activity on the inputs.
      for (int i = 0; i < 3; i++) begin
         bus.req     = 4'($urandom);
         bus.wr_data = $urandom;
         tick(1);
      end
      check("rst_q",   32'(bus.q),   32'h00);
      check("rst_gnt", 32'(bus.gnt), 32'h0);
      bus.req = '0;
      rst = 1'b1;
      tick(1);
      check("idle_after_rst_busy", 32'(bus.busy), 32'h0);

      // Single requester, two beats then voluntary drop.
      bus.req = 4'b0010;
      set_data(1, 8'hA5);
      tick(1);
      check("single_gnt", 32'(bus.gnt), 32'h2);
      tick(1);
      check("single_q1", 32'(bus.q), 32'hA5);
      set_data(1, 8'h3C);
      tick(1);
      check("single_q2", 32'(bus.q), 32'h3C);
      bus.req = '0;
      tick(1);
      check("single_rel_gnt", 32'(bus.gnt), 32'h0);
      check("single_rel_q",   32'(bus.q),   32'h3C);

      // Fresh reset, then two simultaneous one-beat requesters.
      rst = 1'b0;
      tick(1);
      rst = 1'b1;
      bus.req = 4'b0101;
      set_data(0, 8'h5A);
      set_data(2, 8'hC3);
      tick(1);
      check("simul_gnt0", 32'(bus.gnt), 32'h1);
      tick(1);
      check("simul_q0", 32'(bus.q), 32'h5A);
      bus.req = 4'b0100;
      tick(1);
      check("simul_idle", 32'(bus.gnt), 32'h0);
      tick(1);
      check("simul_gnt2", 32'(bus.gnt), 32'h4);
      tick(1);
      check("simul_q2", 32'(bus.q), 32'hC3);
      bus.req = '0;
      tick(1);

      // Hold limit: requester 3 streams, requester 1 waits.
      bus.req = 4'b1010;
      set_data(3, 8'h10);
      set_data(1, 8'hE1);
      tick(1);
      check("hold_gnt3", 32'(bus.gnt), 32'h8);
      for (int b = 0; b < MH; b++) begin
         tick(1);
         set_data(3, 8'h11 + 8'(b));
      end
      check("hold_q_end", 32'(bus.q),   32'h13);
      check("hold_rel",   32'(bus.gnt), 32'h0);
      tick(1);
      check("hold_next_gnt1", 32'(bus.gnt), 32'h2);
      bus.req = '0;
      tick(2);

      // Sole continuous requester: repeating 4-grant/1-idle pattern.
      bus.req = 4'b1000;
      for (int c = 0; c < 12; c++) begin
         set_data(3, 8'h40 + 8'(c));
         tick(1);
      end
      bus.req = '0;
      tick(2);

      // Asynchronous reset in the middle of a grant to requester 2.
      bus.req = 4'b0100;
      set_data(2, 8'h66);
      tick(2);
      set_data(2, 8'h77);
      tick(1);
      check("async_pre_q", 32'(bus.q), 32'h77);
      rst = 1'b0;
      #1;
      check("async_gnt",  32'(bus.gnt),  32'h0);
      check("async_busy", 32'(bus.busy), 32'h0);
      check("async_q",    32'(bus.q),    32'h00);
      bus.req = 4'b0110;
      set_data(1, 8'h99);
      rst = 1'b1;
      tick(1);
      check("async_restart_gnt",   32'(bus.gnt),   32'h2);
      check("async_restart_owner", 32'(bus.owner), 32'h1);
      tick(1);
      bus.req = '0;
      tick(3);

      model_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/reg_share_arbiter.md
# reg_share_arbiter

Round-robin write arbiter for a shared enable register. Up to N_REQ requesters compete to load one WIDTH-bit register. The arbiter grants one requester at a time and writes that requester's data into the register while its request stays high. A grant is capped at MAX_HOLD write beats, then access is forced to rotate. The block sits between the requester logic and the shared `q` storage, and is the only writer of that register.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, shared register width
- MAX_HOLD, 4, maximum write beats per grant (>=1)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- req  input  N_REQ  request vector, bit i = requester i
- wr_data  input  N_REQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- gnt  output  N_REQ  one-hot grant (all-zero when idle), registered
- owner  output  $clog2(N_REQ)  index of current/last grantee, registered
- busy  output  1  high while in GRANT state
- q  output  WIDTH  shared register contents

## Operation
- Two states:
  - IDLE: no grant held.
  - GRANT: one requester owns the register.
- Internal state:
  - `last`: round-robin pointer, the index of the previous grantee.
  - `hold_cnt`: 0..MAX_HOLD-1.
- Reset values (applied asynchronously while rst=0):
  - state=IDLE, gnt=0, owner=0, busy=0, q=0.
  - last=N_REQ-1, so requester 0 has first priority; hold_cnt=0.
- IDLE, at each clock edge:
  - If req==0: stay in IDLE.
  - Otherwise the winner is the first set req bit found scanning upward (wrapping) from last+1.
  - Then: gnt<=onehot(winner), owner<=winner, busy<=1, hold_cnt<=0, state<=GRANT.
- GRANT, at each clock edge, with owner = o:
  - If req[o]=1:
    - q<=wr_data[o]; this is one write beat.
    - If hold_cnt==MAX_HOLD-1: release after this beat (forced rotation).
    - Else: hold_cnt<=hold_cnt+1.
  - If req[o]=0: no write; release.
  - Release means: gnt<=0, busy<=0, last<=o, hold_cnt<=0, state<=IDLE.
- Requests from non-owners are ignored during GRANT. They are arbitrated at the next IDLE edge.
- Requesters see gnt as the acknowledgement: each edge with gnt[i]=1 and req[i]=1 consumes one beat of wr_data[i].
- q changes only on write beats. It holds its value in IDLE and on release edges.

## Timing
- Request to grant: req[i] sampled at IDLE edge k gives gnt[i]=1 after edge k.
- First write lands at edge k+1 (q valid after k+1) if req[i] is still high.
- wr_data[i] must be stable before every edge at which gnt[i]=1 and req[i]=1.
- Release always costs one IDLE cycle. Minimum period between grants is 2 cycles, because the release edge and the arbitration edge are separate.
- A grant of B beats (B<=MAX_HOLD):
  - Voluntary drop: gnt is high for B+1 edges when req drops after B beats.
  - Forced release: gnt is high for exactly MAX_HOLD edges.
- Forced release with the same requester still the only one asking: it regains the grant after one IDLE cycle with hold_cnt=0.
- Forced release with others pending: the next index above the old owner wins, which gives fairness.
- Reset asserted mid-grant:
  - Outputs clear immediately, without waiting for a clock edge.
  - The in-flight beat is dropped; q=0.
  - After rst deasserts, arbitration restarts from requester 0.
- req must not change in the same cycle as the edge sampling it (setup applies). There are no combinational paths from input to output.

## Test plan
- Reset: hold rst=0 with random req/wr_data → q=0x00, gnt=4'b0000, owner=0, busy=0 throughout. Release rst: first edge with req=0 leaves all outputs unchanged.
- Single requester: req=4'b0010, wr_data[1]=0xA5 then 0x3C for 2 beats, then req=0 → gnt=4'b0010 one edge after req, q=0xA5 then 0x3C, gnt=0 and busy=0 on the edge after req drops, q stays 0x3C.
- Simultaneous requests after reset: req=4'b0101, each requester drops after 1 beat → gnt=0001 first, one idle cycle, then gnt=0100; q shows wr_data[0] then wr_data[2].
- Hold limit: req[3]=1 continuously with data 0x10,0x11,0x12,0x13,0x14…, and req[1]=1 pending → exactly 4 writes (q ends 0x13), gnt[3] high 4 edges, idle cycle, then gnt=0010.
- Sole continuous requester: req=4'b1000 held high for 12 cycles → pattern of 4 grant cycles + 1 idle cycle repeats, with 4 writes per grant.
- Async reset mid-grant: during the second beat of a grant to requester 2 (q=0x77), pulse rst low between edges → gnt=0, busy=0, q=0x00 immediately. After release with req=4'b0110, requester 1 is granted first.
